// File: rtl/sfu_operand_prep.sv
// SFU front-end: classifies FP32 operands, fetches polynomial coefficients from
// an external synchronous ROM, and hands c0/c1/c2/y plus control to the evaluator.
module sfu_operand_prep #(
  parameter int EXP_BIAS = 127,
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic        in_precision,
  input  logic [31:0] in_x,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  output logic        lut_en,
  output logic [10:0] lut_addr,
  input  logic [70:0] lut_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [28:0] out_c0,
  output logic [24:0] out_c1,
  output logic [16:0] out_c2,
  output logic [24:0] out_y,
  output logic [8:0]  out_exponent_diff,
  output logic [8:0]  out_exp,
  output logic        out_skip,
  output logic [1:0]  out_special,
  output logic [3:0]  out_opcode,
  output logic        out_precision
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  localparam logic [3:0] OP_SQRT  = 4'd1;
  localparam logic [3:0] OP_RSQRT = 4'd2;
  localparam logic [3:0] OP_FMA   = 4'd6;

  logic [1:0]  state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        prec_q, prec_d;
  logic [10:0] lut_addr_q, lut_addr_d;
  logic [28:0] c0_q, c0_d;
  logic [24:0] c1_q, c1_d;
  logic [16:0] c2_q, c2_d;
  logic [24:0] y_q, y_d;
  logic [8:0]  ediff_q, ediff_d;
  logic [8:0]  exp_q, exp_d;
  logic        skip_q, skip_d;
  logic [1:0]  special_q, special_d;

  function automatic logic [1:0] classify(input logic [31:0] v);
    if (v[30:23] == 8'd0) return 2'b01;
    if (v[30:23] == 8'hFF) return (v[22:0] == 23'd0) ? 2'b10 : 2'b11;
    return 2'b00;
  endfunction

  logic [1:0]  cls_x, cls_b, cls_c, fma_worst;
  logic        sel;
  logic [8:0]  exp_unb;
  logic [10:0] ediff_raw;
  logic [8:0]  ediff_sat;
  logic [24:0] mag_a, fma_c1, fma_y;
  logic [28:0] mag_c, fma_c0;

  // Operand decode works straight off the input bus so every output field is
  // ready at the accept edge; only c0/c1/c2 of the LUT path arrive later.
  always_comb begin
    cls_x = classify(in_x);
    cls_b = classify(in_b);
    cls_c = classify(in_c);
    if (cls_x == 2'b11 || cls_b == 2'b11 || cls_c == 2'b11)      fma_worst = 2'b11;
    else if (cls_x == 2'b10 || cls_b == 2'b10 || cls_c == 2'b10) fma_worst = 2'b10;
    else                                                         fma_worst = 2'b00;
    // Upper table half selected when the unbiased exponent is odd.
    sel       = (in_opcode == OP_SQRT || in_opcode == OP_RSQRT) && !in_x[23];
    exp_unb   = {1'b0, in_x[30:23]} - 9'(EXP_BIAS);
    ediff_raw = {3'b000, in_x[30:23]} + {3'b000, in_b[30:23]} - 11'(EXP_BIAS)
              - {3'b000, in_c[30:23]};
    if ($signed(ediff_raw) > 11'sd255)       ediff_sat = 9'h0FF;
    else if ($signed(ediff_raw) < -11'sd255) ediff_sat = 9'h101;
    else                                     ediff_sat = ediff_raw[8:0];
    mag_a  = {2'b01, in_x[22:0]};
    mag_c  = {3'b001, in_c[22:0], 3'b000};
    fma_c1 = (in_x[31] ^ in_b[31]) ? -mag_a : mag_a;
    fma_c0 = in_c[31] ? -mag_c : mag_c;
    fma_y  = {2'b01, in_b[22:0]};
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    prec_d     = prec_q;
    lut_addr_d = lut_addr_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    y_d        = y_q;
    ediff_d    = ediff_q;
    exp_d      = exp_q;
    skip_d     = skip_q;
    special_d  = special_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opcode_d   = in_opcode;
          prec_d     = in_precision;
          exp_d      = exp_unb;
          lut_addr_d = {in_opcode, sel, in_x[22 -: IDX_BITS]};
          c0_d       = '0;
          c1_d       = '0;
          c2_d       = '0;
          y_d        = '0;
          ediff_d    = '0;
          skip_d     = 1'b1;
          special_d  = 2'b00;
          if (in_opcode == OP_FMA) begin
            state_d   = S_OUT;
            special_d = fma_worst;
            if (fma_worst == 2'b00) begin
              c0_d = fma_c0;
              // Zero/denormal product: the addend alone flows through.
              if (cls_x != 2'b01 && cls_b != 2'b01) begin
                c1_d    = fma_c1;
                y_d     = fma_y;
                ediff_d = ediff_sat;
                skip_d  = 1'b0;
              end
            end
          end else if (cls_x != 2'b00) begin
            state_d   = S_OUT;
            special_d = cls_x;
          end else begin
            state_d = S_FETCH;
            skip_d  = 1'b0;
            y_d     = {{(25 - (23 - IDX_BITS)){1'b0}}, in_x[22 - IDX_BITS:0]};
          end
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        c0_d    = lut_rdata[70:42];
        c1_d    = lut_rdata[41:17];
        c2_d    = lut_rdata[16:0];
        state_d = S_OUT;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      prec_q     <= 1'b0;
      lut_addr_q <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      y_q        <= '0;
      ediff_q    <= '0;
      exp_q      <= '0;
      skip_q     <= 1'b0;
      special_q  <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      prec_q     <= prec_d;
      lut_addr_q <= lut_addr_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      y_q        <= y_d;
      ediff_q    <= ediff_d;
      exp_q      <= exp_d;
      skip_q     <= skip_d;
      special_q  <= special_d;
    end
  end

  assign in_ready          = rst_n && (state_q == S_IDLE);
  assign lut_en            = (state_q == S_FETCH);
  assign lut_addr          = lut_en ? lut_addr_q : 11'd0;
  assign out_valid         = (state_q == S_OUT);
  assign out_c0            = c0_q;
  assign out_c1            = c1_q;
  assign out_c2            = c2_q;
  assign out_y             = y_q;
  assign out_exponent_diff = ediff_q;
  assign out_exp           = exp_q;
  assign out_skip          = skip_q;
  assign out_special       = special_q;
  assign out_opcode        = opcode_q;
  assign out_precision     = prec_q;

endmodule

// File: tb/tb_sfu_operand_prep.sv
// Randomized and directed bench for sfu_operand_prep with an arithmetic reference
// model, a ROM model driving lut_rdata, and a per-cycle compare process.
module tb_sfu_operand_prep;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic        in_precision = 1'b0;
  logic [31:0] in_x = '0, in_b = '0, in_c = '0;
  logic        lut_en;
  logic [10:0] lut_addr;
  logic [70:0] lut_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [28:0] out_c0;
  logic [24:0] out_c1;
  logic [16:0] out_c2;
  logic [24:0] out_y;
  logic [8:0]  out_exponent_diff;
  logic [8:0]  out_exp;
  logic        out_skip;
  logic [1:0]  out_special;
  logic [3:0]  out_opcode;
  logic        out_precision;

  always #5 clk = ~clk;

  sfu_operand_prep dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_precision(in_precision), .in_x(in_x), .in_b(in_b),
    .in_c(in_c), .lut_en(lut_en), .lut_addr(lut_addr), .lut_rdata(lut_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_c0(out_c0), .out_c1(out_c1),
    .out_c2(out_c2), .out_y(out_y), .out_exponent_diff(out_exponent_diff),
    .out_exp(out_exp), .out_skip(out_skip), .out_special(out_special),
    .out_opcode(out_opcode), .out_precision(out_precision)
  );

  logic [70:0] rom [0:2047];

  // Synchronous ROM; garbage on cycles with no read so mistimed capture shows up.
  always @(posedge clk)
    lut_rdata <= lut_en ? rom[lut_addr] : 71'({$urandom(), $urandom(), $urandom()});

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [28:0] c0;
    logic [24:0] c1;
    logic [16:0] c2;
    logic [24:0] y;
    logic [8:0]  ediff;
    logic [8:0]  ex;
    logic        skip;
    logic [1:0]  special;
    logic [3:0]  op;
    logic        prec;
    logic        uses_lut;
    logic [10:0] addr;
    int          fetch_cnt;
  } exp_t;

  exp_t q[$];

  function automatic int cls_of(input logic [31:0] v);
    int e;
    e = int'(v[30:23]);
    if (e == 0) return 1;
    if (e == 255) return (v[22:0] == 23'd0) ? 2 : 3;
    return 0;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic p,
                                 input logic [31:0] x, input logic [31:0] b,
                                 input logic [31:0] c);
    exp_t m;
    int ea, eb, ec, ma, mb, mc, ca, cb, cc, d, cval, sel, worst;
    logic [70:0] r;
    ea = int'(x[30:23]); eb = int'(b[30:23]); ec = int'(c[30:23]);
    ma = int'(x[22:0]);  mb = int'(b[22:0]);  mc = int'(c[22:0]);
    ca = cls_of(x); cb = cls_of(b); cc = cls_of(c);
    m = '{default: 0};
    m.op = op; m.prec = p; m.ex = 9'(ea - 127);
    if (op != 4'd6) begin
      if (ca != 0) begin
        m.special = 2'(ca);
        m.skip = 1'b1;
      end else begin
        sel = (((op == 4'd1) || (op == 4'd2)) && (((ea - 127) % 2) != 0)) ? 1 : 0;
        m.uses_lut = 1'b1;
        m.addr = 11'(int'(op) * 128 + sel * 64 + ma / 131072);
        r = rom[m.addr];
        m.c0 = r[70:42]; m.c1 = r[41:17]; m.c2 = r[16:0];
        m.y = 25'(ma % 131072);
      end
    end else begin
      worst = 0;
      if (ca == 3 || cb == 3 || cc == 3) worst = 3;
      else if (ca == 2 || cb == 2 || cc == 2) worst = 2;
      if (worst != 0) begin
        m.special = 2'(worst);
        m.skip = 1'b1;
      end else begin
        cval = (8388608 + mc) * 8;
        m.c0 = c[31] ? 29'(-cval) : 29'(cval);
        if (ca == 1 || cb == 1) m.skip = 1'b1;
        else begin
          m.c1 = 25'((x[31] != b[31]) ? -(8388608 + ma) : (8388608 + ma));
          m.y  = 25'(8388608 + mb);
          d = ea + eb - 127 - ec;
          if (d > 255) d = 255;
          if (d < -255) d = -255;
          m.ediff = 9'(d);
        end
      end
    end
    return m;
  endfunction

  int          lut_total = 0;
  logic [10:0] last_lut_addr;

  always @(negedge clk) begin
    exp_t h;
    if (rst_n) begin
      if (lut_en) begin
        lut_total++;
        last_lut_addr = lut_addr;
        if (q.size() == 0) chk("lut_en_spurious", 32'(lut_en), 32'd0);
        else begin
          h = q[0];
          chk("lut_en_path", 32'(lut_en), 32'(h.uses_lut));
          chk("lut_addr", 32'(lut_addr), 32'(h.addr));
          h.fetch_cnt++;
          q[0] = h;
        end
      end
      if (out_valid) begin
        if (q.size() == 0) chk("out_valid_spurious", 32'(out_valid), 32'd0);
        else begin
          h = q[0];
          chk("c0", 32'(out_c0), 32'(h.c0));
          chk("c1", 32'(out_c1), 32'(h.c1));
          chk("c2", 32'(out_c2), 32'(h.c2));
          chk("y", 32'(out_y), 32'(h.y));
          chk("ediff", 32'(out_exponent_diff), 32'(h.ediff));
          chk("exp", 32'(out_exp), 32'(h.ex));
          chk("skip", 32'(out_skip), 32'(h.skip));
          chk("special", 32'(out_special), 32'(h.special));
          chk("opcode", 32'(out_opcode), 32'(h.op));
          chk("precision", 32'(out_precision), 32'(h.prec));
          chk("in_ready_busy", 32'(in_ready), 32'd0);
          if (out_ready) begin
            chk("fetch_count", 32'(h.fetch_cnt), 32'(h.uses_lut));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  logic [28:0] s_c0;
  logic [24:0] s_c1, s_y;
  logic [16:0] s_c2;
  logic [8:0]  s_ediff, s_exp;
  logic        s_skip;
  logic [1:0]  s_special;
  int          s_lut;

  task automatic do_op(input logic [3:0] op, input logic p, input logic [31:0] x,
                       input logic [31:0] b, input logic [31:0] c, input int hold);
    int waitc, lat, lut_before;
    exp_t e;
    waitc = 0;
    while (!in_ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    e = model(op, p, x, b, c);
    q.push_back(e);
    last_lut_addr = 11'h7FF;
    lut_before = lut_total;
    in_valid = 1'b1; in_opcode = op; in_precision = p; in_x = x; in_b = b; in_c = c;
    @(posedge clk); #1;
    in_valid = 1'b0; in_opcode = 4'($urandom()); in_precision = 1'($urandom());
    in_x = $urandom(); in_b = $urandom(); in_c = $urandom();
    lat = 1;
    while (!out_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), e.uses_lut ? 32'd3 : 32'd1);
    s_c0 = out_c0; s_c1 = out_c1; s_c2 = out_c2; s_y = out_y;
    s_ediff = out_exponent_diff; s_exp = out_exp; s_skip = out_skip; s_special = out_special;
    s_lut = lut_total - lut_before;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_xfer", 32'(out_valid), 32'd0);
    chk("in_ready_after_xfer", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'd0;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: v[30:23] = 8'hFF;
      3: ;
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 71'({$urandom(), $urandom(), $urandom()});
    rom[11'h080] = 71'h123456789ABCDEF;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_lut_en", 32'(lut_en), 32'd0);
    chk("rst_c0", 32'(out_c0), 32'd0);
    chk("rst_special", 32'(out_special), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // SQRT 4.0: biased exponent 129 -> unbiased 2 (even), lower table half
    do_op(4'd1, 1'b1, 32'h40800000, 32'h0, 32'h0, 0);
    chk("sqrt_addr", 32'(last_lut_addr), 32'h080);
    chk("sqrt_lut_cycles", 32'(s_lut), 32'd1);
    chk("sqrt_c0", 32'(s_c0), 32'h00048D1);
    chk("sqrt_c1", 32'(s_c1), 32'h0B3C4D5);
    chk("sqrt_c2", 32'(s_c2), 32'h1CDEF);
    chk("sqrt_y", 32'(s_y), 32'd0);
    chk("sqrt_exp", 32'(s_exp), 32'd2);
    chk("sqrt_skip", 32'(s_skip), 32'd0);

    do_op(4'd0, 1'b0, 32'h3FC00000, 32'h0, 32'h0, 1);
    chk("rcp_addr", 32'(last_lut_addr), 32'h020);
    chk("rcp_y", 32'(s_y), 32'd0);
    chk("rcp_ediff", 32'(s_ediff), 32'd0);

    do_op(4'd6, 1'b0, 32'h40000000, 32'h40400000, 32'h3F800000, 0);
    chk("fma_no_lut", 32'(s_lut), 32'd0);
    chk("fma_c1", 32'(s_c1), 32'h0800000);
    chk("fma_y", 32'(s_y), 32'h0C00000);
    chk("fma_c0", 32'(s_c0), 32'h04000000);
    chk("fma_ediff", 32'(s_ediff), 32'd2);
    chk("fma_skip", 32'(s_skip), 32'd0);

    do_op(4'd6, 1'b1, 32'h00000000, 32'h40A00000, 32'hBFC00000, 2);
    chk("fma0_skip", 32'(s_skip), 32'd1);
    chk("fma0_c0", 32'(s_c0), 32'h1A000000);
    chk("fma0_ediff", 32'(s_ediff), 32'd0);

    do_op(4'd0, 1'b0, 32'h7FC00000, 32'h0, 32'h0, 0);
    chk("nan_special", 32'(s_special), 32'd3);
    chk("nan_skip", 32'(s_skip), 32'd1);
    chk("nan_no_lut", 32'(s_lut), 32'd0);

    do_op(4'd0, 1'b0, 32'h00000000, 32'h0, 32'h0, 0);
    chk("zero_special", 32'(s_special), 32'd1);
    chk("zero_skip", 32'(s_skip), 32'd1);

    do_op(4'd6, 1'b0, 32'h7F000000, 32'h7F000000, 32'h00800000, 0);
    chk("sat_pos", 32'(s_ediff), 32'h0FF);
    do_op(4'd6, 1'b0, 32'h00800000, 32'h00800000, 32'h7F000000, 0);
    chk("sat_neg", 32'(s_ediff), 32'h101);
    do_op(4'd6, 1'b0, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 0);
    chk("fma_nan_special", 32'(s_special), 32'd3);
    chk("fma_nan_skip", 32'(s_skip), 32'd1);

    // Backpressure: five stalled cycles in OUT, compare process checks stability
    do_op(4'd2, 1'b1, 32'h41200000, 32'h0, 32'h0, 5);

    // Reset during FETCH
    in_valid = 1'b1; in_opcode = 4'd3; in_x = 32'h3FA00000; in_precision = 1'b0;
    q.push_back(model(4'd3, 1'b0, 32'h3FA00000, 32'h0, 32'h0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_fetch_lut_en", 32'(lut_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_lut_en", 32'(lut_en), 32'd0);
    chk("midrst_lut_addr", 32'(lut_addr), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_y", 32'(out_y), 32'd0);
    chk("midrst_exp", 32'(out_exp), 32'd0);
    chk("midrst_opcode", 32'(out_opcode), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_rst_idle_valid", 32'(out_valid), 32'd0);
      chk("post_rst_idle_lut", 32'(lut_en), 32'd0);
    end

    for (int i = 0; i < 150; i++)
      do_op(4'($urandom_range(0, 8)), 1'($urandom()), rand_fp(), rand_fp(), rand_fp(),
            $urandom_range(0, 3));

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
